// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB slave types and constants
package apb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam logic [APB_DATA_W-1:0] APB_ID = 32'hA9B0_0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_DONE
    } apb_state_e;
endpackage

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - register array with one write port and one combinational read port
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [29:0]           wr_idx,
    input  logic [APB_DATA_W-1:0] wr_data,
    input  logic [29:0]           rd_idx,
    output logic [APB_DATA_W-1:0] rd_data
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];
    logic                  wr_hit;

    // Index 0 is the read-only ID word, so its storage slot is never written.
    assign wr_hit = wr_en && (wr_idx != '0) && (wr_idx < 30'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_idx[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx == '0) begin
            rd_data = APB_ID;
        end else if (rd_idx < 30'(NUM_REGS)) begin
            rd_data = regs[rd_idx[IDX_W-1:0]];
        end
    end
endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register slave with configurable wait states
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready
);
    apb_state_e            state_q, state_cur, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [APB_ADDR_W-1:0] addr_q, addr_eff, offset_rd, offset_wr;
    logic [APB_DATA_W-1:0] wdata_q, rd_data, rdata_d;
    logic                  write_q, write_eff, setup, wr_en, pready_d;
    logic                  unused_low;

    // The setup cycle is observed while the register still reads IDLE, so the
    // SETUP decision is taken combinationally and costs no extra cycle.
    assign setup     = (state_q == ST_IDLE) && psel && !penable;
    assign state_cur = setup ? ST_SETUP : state_q;
    assign addr_eff  = setup ? paddr : addr_q;
    assign write_eff = setup ? pwrite : write_q;

    assign offset_rd  = addr_eff - BASE_ADDR;
    assign offset_wr  = addr_q - BASE_ADDR;
    assign unused_low = ^{offset_rd[1:0], offset_wr[1:0]};

    always_comb begin
        state_d  = state_cur;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        case (state_cur)
            ST_IDLE: state_d = ST_IDLE;
            ST_SETUP: begin
                if (WAIT_CYCLES == 0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                wr_en   = psel && penable && write_q;
            end
            default: state_d = ST_IDLE;
        endcase
        pready_d = (state_d == ST_DONE);
        rdata_d  = (pready_d && !write_eff) ? rd_data : '0;
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pready  <= pready_d;
            prdata  <= rdata_d;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    apb_reg_bank #(
        .NUM_REGS(NUM_REGS)
    ) u_bank (
        .clk    (pclk),
        .rst    (prst),
        .wr_en  (wr_en),
        .wr_idx (offset_wr[31:2]),
        .wr_data(wdata_q),
        .rd_idx (offset_rd[31:2]),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - self-checking bench for apb_reg_slave (WAIT_CYCLES 0 and 3)
module tb_apb_reg_slave;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        pclk = 1'b0;
    logic        prst;
    logic [31:0] paddr_v   [2];
    logic        psel_v    [2];
    logic        penable_v [2];
    logic        pwrite_v  [2];
    logic [31:0] pwdata_v  [2];
    logic [31:0] prdata_w  [2];
    logic        pready_w  [2];

    int tests, fails;
    bit chk_en;

    // reference model state
    int          cyc;
    bit          busy      [2];
    int          done_cyc  [2];
    logic [31:0] m_addr    [2];
    logic [31:0] m_data    [2];
    bit          m_wr      [2];
    logic [31:0] mem       [2][16];
    logic        exp_pready[2];
    logic [31:0] exp_prdata[2];

    always #5 pclk = ~pclk;

    apb_reg_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .pclk(pclk), .prst(prst), .paddr(paddr_v[0]), .psel(psel_v[0]), .penable(penable_v[0]),
        .pwrite(pwrite_v[0]), .pwdata(pwdata_v[0]), .prdata(prdata_w[0]), .pready(pready_w[0]));

    apb_reg_slave #(.NUM_REGS(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut3 (
        .pclk(pclk), .prst(prst), .paddr(paddr_v[1]), .psel(psel_v[1]), .penable(penable_v[1]),
        .pwrite(pwrite_v[1]), .pwdata(pwdata_v[1]), .prdata(prdata_w[1]), .pready(pready_w[1]));

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] mread(input int d, input logic [31:0] a);
        logic [31:0] idx;
        idx = a >> 2;
        if (idx == 0) return ID;
        if (idx < 16) return mem[d][idx];
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer k starts at setup cycle S and completes at S+1+W unless psel drops earlier.
    always @(posedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            if (prst) begin
                busy[d] = 1'b0;
                for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
            end else if (busy[d]) begin
                if (cyc == done_cyc[d]) begin
                    if (psel_v[d] && penable_v[d] && m_wr[d] &&
                        (m_addr[d] >> 2) != 0 && (m_addr[d] >> 2) < 16)
                        mem[d][m_addr[d] >> 2] = m_data[d];
                    busy[d] = 1'b0;
                end else if (!psel_v[d]) begin
                    busy[d] = 1'b0;
                end
            end else if (psel_v[d] && !penable_v[d]) begin
                busy[d]     = 1'b1;
                done_cyc[d] = cyc + 1 + wc(d);
                m_addr[d]   = paddr_v[d];
                m_data[d]   = pwdata_v[d];
                m_wr[d]     = pwrite_v[d];
            end
        end
        cyc++;
        for (int d = 0; d < 2; d++) begin
            exp_pready[d] = busy[d] && (cyc == done_cyc[d]);
            exp_prdata[d] = (exp_pready[d] && !m_wr[d]) ? mread(d, m_addr[d]) : 32'h0;
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("cycle_pready_dut%0d", d), 32'(pready_w[d]), 32'(exp_pready[d]));
                chk($sformatf("cycle_prdata_dut%0d", d), prdata_w[d], exp_prdata[d]);
            end
        end
    end

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int abort_at, output logic [31:0] rdata, output int lat, output bit got);
        rdata = 32'h0;
        got   = 1'b0;
        lat   = 1;
        psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
        paddr_v[d] = addr; pwdata_v[d] = data;
        @(posedge pclk); #1;
        penable_v[d] = 1'b1;
        lat = 2;
        for (int k = 0; k < 40 && !got; k++) begin
            if (abort_at == lat) begin
                psel_v[d] = 1'b0; penable_v[d] = 1'b0;
                @(posedge pclk); #1;
                return;
            end
            if (pready_w[d]) begin
                got   = 1'b1;
                rdata = prdata_w[d];
                @(posedge pclk); #1;
            end else begin
                @(posedge pclk); #1;
                lat++;
            end
        end
        psel_v[d] = 1'b0; penable_v[d] = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL xfer_timeout dut%0d addr %h: pready not seen within bound", d, addr);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got %0d failures so far", fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, addr, data;
        int lat, gap, d, ab;
        bit got, seen;
        logic [31:0] vals [3];

        tests = 0; fails = 0; chk_en = 1'b0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; done_cyc[i] = 0; m_wr[i] = 1'b0; m_addr[i] = 0; m_data[i] = 0;
            exp_pready[i] = 1'b0; exp_prdata[i] = 32'h0;
            psel_v[i] = 1'b0; penable_v[i] = 1'b0; pwrite_v[i] = 1'b0;
            paddr_v[i] = 32'h0; pwdata_v[i] = 32'h0;
        end
        prst = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        chk_en = 1'b1;
        chk("reset_pready_w0", 32'(pready_w[0]), 32'h0);
        chk("reset_prdata_w0", prdata_w[0], 32'h0);
        chk("reset_pready_w3", 32'(pready_w[1]), 32'h0);
        prst = 1'b0;

        // first transfer right after reset; WAIT_CYCLES=0 round trip
        xfer(0, 1, 32'h04, 32'h1234_5678, 0, rd, lat, got);
        chk("w0_write_latency", 32'(lat), 32'd2);
        xfer(0, 0, 32'h04, 32'h0, 0, rd, lat, got);
        chk("w0_read_latency", 32'(lat), 32'd2);
        chk("w0_read_data", rd, 32'h1234_5678);

        // ID register, WAIT_CYCLES=3
        xfer(1, 0, 32'h00, 32'h0, 0, rd, lat, got);
        chk("w3_read_latency", 32'(lat), 32'd5);
        chk("w3_read_id", rd, ID);
        xfer(1, 1, 32'h00, 32'hFFFF_FFFF, 0, rd, lat, got);
        xfer(1, 0, 32'h00, 32'h0, 0, rd, lat, got);
        chk("w3_id_readonly", rd, ID);

        // out of range
        xfer(0, 1, 32'h40, 32'h0000_CAFE, 0, rd, lat, got);
        xfer(0, 0, 32'h40, 32'h0, 0, rd, lat, got);
        chk("oor_read_zero", rd, 32'h0);
        xfer(0, 0, 32'h04, 32'h0, 0, rd, lat, got);
        chk("oor_reg1_kept", rd, 32'h1234_5678);

        // abort in WAIT
        xfer(1, 1, 32'h08, 32'h1111_2222, 0, rd, lat, got);
        xfer(1, 1, 32'h08, 32'h3333_4444, 3, rd, lat, got);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (pready_w[1]) seen = 1'b1;
            @(posedge pclk); #1;
        end
        chk("abort_no_pready", 32'(seen), 32'h0);
        xfer(1, 0, 32'h08, 32'h0, 0, rd, lat, got);
        chk("abort_old_value", rd, 32'h1111_2222);

        // back-to-back, no idle cycles between transfers
        for (int dd = 0; dd < 2; dd++) begin
            vals[0] = 32'hA000_0004 + dd; vals[1] = 32'hB000_0008 + dd; vals[2] = 32'hC000_000C + dd;
            for (int i = 0; i < 3; i++) begin
                xfer(dd, 1, 32'(4 * (i + 1)), vals[i], 0, rd, lat, got);
                chk($sformatf("b2b_wr_lat_dut%0d_%0d", dd, i), 32'(lat), 32'(2 + wc(dd)));
            end
            for (int i = 0; i < 3; i++) begin
                xfer(dd, 0, 32'(4 * (i + 1)), 32'h0, 0, rd, lat, got);
                chk($sformatf("b2b_rd_lat_dut%0d_%0d", dd, i), 32'(lat), 32'(2 + wc(dd)));
                chk($sformatf("b2b_rd_data_dut%0d_%0d", dd, i), rd, vals[i]);
            end
        end

        // randomized traffic, checked cycle by cycle against the model
        for (int t = 0; t < 300; t++) begin
            d   = $urandom_range(0, 1);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge pclk); #1; end
            if ($urandom_range(0, 7) == 0) begin
                psel_v[d] = 1'b1; penable_v[d] = 1'b1; paddr_v[d] = $urandom();
                @(posedge pclk); #1;
                psel_v[d] = 1'b0; penable_v[d] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) addr = $urandom();
            else addr = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            data = $urandom();
            ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 2 + wc(d)) : 0;
            xfer(d, 1'($urandom_range(0, 1)), addr, data, ab, rd, lat, got);
        end

        // reset pulse during WAIT of a write
        xfer(1, 1, 32'h0C, 32'h0000_0055, 0, rd, lat, got);
        psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
        paddr_v[1] = 32'h0C; pwdata_v[1] = 32'h0000_0077;
        @(posedge pclk); #1;
        penable_v[1] = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b0; psel_v[1] = 1'b0; penable_v[1] = 1'b0;
        chk("reset_abort_pready", 32'(pready_w[1]), 32'h0);
        repeat (4) begin @(posedge pclk); #1; end
        xfer(1, 0, 32'h0C, 32'h0, 0, rd, lat, got);
        chk("reset_cleared_reg3", rd, 32'h0);
        xfer(0, 0, 32'h04, 32'h0, 0, rd, lat, got);
        chk("reset_cleared_dut0", rd, 32'h0);

        repeat (3) begin @(posedge pclk); #1; end
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
